// File: rtl/bubsysrom_snddma_arbiter.sv
// bubsysrom_snddma_arbiter
//   Hands the sound bus between the Z80 sound CPU and the 68k DMA port into
//   sound RAM. Synchronises the 68k bus request, gates it with the CPU-set DMA
//   enable, runs the Z80 BUSRQ/BUSAK handshake and returns the grant to the 68k.
//   While granted, turns asynchronous 68k strobes into single-cycle sound-bus
//   pulses, captures read data and generates DTACK.
//
// Ports
//   i_EMU_MCLK        master clock (rising edge)
//   i_EMU_INITRST_n   asynchronous active-low reset
//   i_SNDCPU_RST      synchronous clear, same effect as reset
//   i_DMAEN_WR        DMA-enable write strobe; enable set on its falling edge
//   i_DMA_BR          68k bus request (async)      o_DMA_BG_n   68k bus grant
//   o_SNDCPU_BUSRQ_n  Z80 BUSRQ_n                  i_SNDCPU_BUSAK_n  Z80 BUSAK_n
//   i_DMA_RnW, i_DMA_LDS_n, i_DMA_SNDRAM_CS        68k access (async)
//   o_BUS_SEL         DMA owns the sound bus
//   o_BUS_MREQ_n, o_BUS_WR_n, o_BUS_RD_n           one-cycle sound-bus pulses
//   i_BUS_DI          sound-bus read data          o_DMA_DI     latched read data
//   o_DMA_DTACK_n     68k data acknowledge         o_ACK_TIMEOUT sticky BUSAK abort
module bubsysrom_snddma_arbiter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRB_STAGES = 3,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned ACK_TO      = 1023
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_INITRST_n,
    input  logic       i_SNDCPU_RST,
    input  logic       i_DMAEN_WR,
    input  logic       i_DMA_BR,
    output logic       o_DMA_BG_n,
    output logic       o_SNDCPU_BUSRQ_n,
    input  logic       i_SNDCPU_BUSAK_n,
    input  logic       i_DMA_RnW,
    input  logic       i_DMA_LDS_n,
    input  logic       i_DMA_SNDRAM_CS,
    output logic       o_BUS_SEL,
    output logic       o_BUS_MREQ_n,
    output logic       o_BUS_WR_n,
    output logic       o_BUS_RD_n,
    input  logic [7:0] i_BUS_DI,
    output logic [7:0] o_DMA_DI,
    output logic       o_DMA_DTACK_n,
    output logic       o_ACK_TIMEOUT
);

    localparam int unsigned CW = $clog2(ACK_TO + 1);
    localparam logic [CW-1:0] ACK_TO_C = CW'(ACK_TO);
    localparam logic [2:0]    RD_LAT_C = 3'(RD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    // ---------------- synchronisers ----------------
    logic [SYNC_STAGES-1:0] br_sync_q, ak_sync_q;
    logic [STRB_STAGES-1:0] wr_sync_q, rd_sync_q;
    logic wr_raw, rd_raw, br_s, ak_s, lds_s, wr_req, rd_req;

    assign wr_raw = i_DMA_RnW | i_DMA_LDS_n;
    assign rd_raw = ~i_DMA_RnW | i_DMA_LDS_n;

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            br_sync_q <= '0;
            ak_sync_q <= '0;
            wr_sync_q <= '1;
            rd_sync_q <= '1;
        end else begin
            br_sync_q[0] <= i_DMA_BR;
            ak_sync_q[0] <= ~i_SNDCPU_BUSAK_n;
            wr_sync_q[0] <= wr_raw;
            rd_sync_q[0] <= rd_raw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                br_sync_q[k] <= br_sync_q[k-1];
                ak_sync_q[k] <= ak_sync_q[k-1];
            end
            for (int unsigned k = 1; k < STRB_STAGES; k++) begin
                wr_sync_q[k] <= wr_sync_q[k-1];
                rd_sync_q[k] <= rd_sync_q[k-1];
            end
        end
    end

    assign br_s   = br_sync_q[SYNC_STAGES-1];
    assign ak_s   = ak_sync_q[SYNC_STAGES-1];
    // Both raw strobes are high exactly when LDS_n is high.
    assign lds_s  = wr_sync_q[STRB_STAGES-1] & rd_sync_q[STRB_STAGES-1];
    assign wr_req = ~wr_sync_q[STRB_STAGES-2] & wr_sync_q[STRB_STAGES-1];
    assign rd_req = ~rd_sync_q[STRB_STAGES-2] & rd_sync_q[STRB_STAGES-1] & ~wr_req;

    // ---------------- control ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    rdc_q, rdc_d;        // read-latency countdown, 0 = idle
    logic [7:0]    di_q, di_d;
    logic          to_q, to_d;
    logic          blk_q, blk_d;        // re-request blocked after timeout
    logic          en_q, en_d;
    logic          dmaen_prev_q;
    logic          wrp_q, wrp_d, rdp_q, rdp_d;
    logic          dtack_q, dtack_d;
    logic          dtack_set, busy;

    assign busy = wrp_q | rdp_q | (rdc_q != 3'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdc_d     = rdc_q;
        di_d      = di_q;
        to_d      = to_q;
        blk_d     = blk_q;
        en_d      = en_q;
        wrp_d     = 1'b0;
        rdp_d     = 1'b0;
        dtack_d   = dtack_q;
        dtack_set = 1'b0;

        if (dmaen_prev_q && !i_DMAEN_WR) en_d = 1'b1;
        if (!br_s) blk_d = 1'b0;

        if (rdc_q != 3'd0) begin
            rdc_d = rdc_q - 3'd1;
            if (rdc_q == 3'd1) begin
                di_d      = i_BUS_DI;
                dtack_set = 1'b1;
            end
        end
        if (wrp_q) dtack_set = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (br_s && en_q && !blk_q) state_d = ST_REQ;
            end
            ST_REQ: begin
                cnt_d = (cnt_q == ACK_TO_C) ? cnt_q : cnt_q + CW'(1);
                if (ak_s) begin
                    state_d = ST_GRANT;
                end else if (!br_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_d == ACK_TO_C) begin
                    to_d    = 1'b1;
                    blk_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (wr_req) begin
                    if (i_DMA_SNDRAM_CS) wrp_d = 1'b1;
                    else                 dtack_set = 1'b1;
                end else if (rd_req) begin
                    if (i_DMA_SNDRAM_CS) begin
                        rdp_d = 1'b1;
                        rdc_d = RD_LAT_C;
                    end else begin
                        dtack_set = 1'b1;
                    end
                end else if (!br_s && !busy) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ak_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Set wins: a CS=0 request is seen while the last LDS stage is still high.
        if (dtack_set)  dtack_d = 1'b0;
        else if (lds_s) dtack_d = 1'b1;
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rdc_q        <= '0;
            di_q         <= '1;
            to_q         <= 1'b0;
            blk_q        <= 1'b0;
            en_q         <= 1'b0;
            dmaen_prev_q <= 1'b0;
            wrp_q        <= 1'b0;
            rdp_q        <= 1'b0;
            dtack_q      <= 1'b1;
        end else if (i_SNDCPU_RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rdc_q        <= '0;
            di_q         <= '1;
            to_q         <= 1'b0;
            blk_q        <= 1'b0;
            en_q         <= 1'b0;
            dmaen_prev_q <= 1'b0;
            wrp_q        <= 1'b0;
            rdp_q        <= 1'b0;
            dtack_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdc_q        <= rdc_d;
            di_q         <= di_d;
            to_q         <= to_d;
            blk_q        <= blk_d;
            en_q         <= en_d;
            dmaen_prev_q <= i_DMAEN_WR;
            wrp_q        <= wrp_d;
            rdp_q        <= rdp_d;
            dtack_q      <= dtack_d;
        end
    end

    assign o_SNDCPU_BUSRQ_n = ~((state_q == ST_REQ) || (state_q == ST_GRANT));
    assign o_DMA_BG_n       = ~(state_q == ST_GRANT);
    assign o_BUS_SEL        = (state_q == ST_GRANT);
    assign o_BUS_MREQ_n     = ~(wrp_q | rdp_q);
    assign o_BUS_WR_n       = ~wrp_q;
    assign o_BUS_RD_n       = ~rdp_q;
    assign o_DMA_DI         = di_q;
    assign o_DMA_DTACK_n    = dtack_q;
    assign o_ACK_TIMEOUT    = to_q;

endmodule

// File: doc/bubsysrom_snddma_arbiter.md
Name: bubsysrom_snddma_arbiter

Overview:
- Owns the sound-bus hand-over between the Z80 sound CPU and the 68k DMA port into sound RAM.
- Synchronises the 68k bus request, gates it with the CPU-set DMA enable, and runs the Z80 BUSRQ/BUSAK handshake. Returns the grant to the 68k.
- While granted, converts asynchronous 68k strobes into single-cycle sound-bus read/write pulses, captures read data, and generates DTACK.
- Sits between the main-CPU interface and the sound-bus mux/address decoder.

Parameters:
- SYNC_STAGES, 2, flip-flop depth for i_DMA_BR and i_SNDCPU_BUSAK_n.
- STRB_STAGES, 3, depth of strobe synchroniser before edge detect (minimum 2).
- RD_LAT, 1, mclk cycles from read pulse to valid i_BUS_DI (1..4).
- ACK_TO, 1023, mclk cycles to wait for BUSAK before abort.

Ports:
- i_EMU_MCLK  in  1  master clock; all logic on the rising edge.
- i_EMU_INITRST_n  in  1  asynchronous active-low reset.
- i_SNDCPU_RST  in  1  synchronous clear of state and enable; same effect as reset.
- i_DMAEN_WR  in  1  decoded DMA-enable write strobe (level, from address decoder).
- i_DMA_BR  in  1  68k bus request, asynchronous, active high.
- o_DMA_BG_n  out  1  bus grant to 68k, active low.
- o_SNDCPU_BUSRQ_n  out  1  to Z80 BUSRQ_n.
- i_SNDCPU_BUSAK_n  in  1  from Z80 BUSAK_n.
- i_DMA_RnW  in  1  68k read/not-write.
- i_DMA_LDS_n  in  1  68k lower data strobe.
- i_DMA_SNDRAM_CS  in  1  68k sound-RAM chip select.
- o_BUS_SEL  out  1  1 = DMA drives sound-bus address, data and strobes.
- o_BUS_MREQ_n  out  1  sound-bus MREQ_n during DMA.
- o_BUS_WR_n  out  1  one-cycle write pulse, active low.
- o_BUS_RD_n  out  1  one-cycle read pulse, active low.
- i_BUS_DI  in  8  sound-bus read data.
- o_DMA_DI  out  8  latched read data to 68k.
- o_DMA_DTACK_n  out  1  data acknowledge, active low.
- o_ACK_TIMEOUT  out  1  sticky abort flag.

Behaviour:

Reset values:
- o_DMA_BG_n = 1, o_SNDCPU_BUSRQ_n = 1, o_BUS_SEL = 0, o_BUS_MREQ_n = 1, o_BUS_WR_n = 1, o_BUS_RD_n = 1.
- o_DMA_DTACK_n = 1, o_DMA_DI = 8'hFF, o_ACK_TIMEOUT = 0, dma_en = 0, state = IDLE.

DMA enable:
- dma_en is set on the falling edge of i_DMAEN_WR (registered previous value 1, current value 0).
- Only reset or i_SNDCPU_RST clears it.

Synchronisation:
- br_s is i_DMA_BR after SYNC_STAGES flops.
- ak_s is ~i_SNDCPU_BUSAK_n after SYNC_STAGES flops.
- Strobes: wr_raw = i_DMA_RnW | i_DMA_LDS_n, rd_raw = ~i_DMA_RnW | i_DMA_LDS_n. Each passes through STRB_STAGES flops.
- A falling edge between the last two stages produces a request.

FSM:
- IDLE: BUSRQ_n = 1. Go to REQ when br_s & dma_en; the timeout counter clears.
- REQ: BUSRQ_n = 0; the counter increments each cycle.
  - ak_s = 1: go to GRANT; BG_n = 0 and BUS_SEL = 1 from the next cycle.
  - br_s = 0: go to IDLE.
  - Counter reaches ACK_TO: set o_ACK_TIMEOUT and go to IDLE. Re-request only after br_s has been observed at 0.
- GRANT: BUSRQ_n = 0, BG_n = 0, BUS_SEL = 1.
  - A write request with i_DMA_SNDRAM_CS = 1: MREQ_n and WR_n low for exactly 1 cycle, then DTACK_n = 0.
  - A read request: MREQ_n and RD_n low for 1 cycle. Capture i_BUS_DI into o_DMA_DI RD_LAT cycles after the pulse, and set DTACK_n = 0 in that same cycle.
  - A request with CS = 0: no bus pulse; DTACK_n = 0 on the next cycle.
  - DTACK_n returns to 1 when the synchronised LDS_n reads 1.
  - br_s = 0 with no access pending: go to RELEASE.
- RELEASE: BG_n = 1 and BUS_SEL = 0 immediately, BUSRQ_n = 1. Go to IDLE when ak_s = 0.

Boundary conditions:
- Simultaneous read and write edges cannot occur (they are exclusive by RnW). If the bench forces both, write wins.
- A strobe edge in any state other than GRANT is discarded.
- br_s dropping while a read is in flight: RELEASE waits until capture completes.
- i_SNDCPU_RST asserted mid-grant: next cycle all outputs take reset values, state = IDLE, dma_en = 0.
- The timeout counter saturates at ACK_TO and does not wrap.

Test Plan:
- Reset, pulse i_DMAEN_WR high then low, raise i_DMA_BR; tie BUSAK_n to follow BUSRQ_n after 4 cycles -> BUSRQ_n = 0 SYNC_STAGES+1 cycles after BR, BG_n = 0 SYNC_STAGES+1 cycles after BUSAK_n low.
- i_DMA_BR raised with dma_en = 0 -> BUSRQ_n stays 1 for 100 cycles; BG_n stays 1.
- In GRANT, write with CS = 1, LDS_n low for 20 cycles -> exactly one WR_n/MREQ_n low cycle, DTACK_n = 0 on the next cycle and held until LDS_n high is synchronised.
- In GRANT, read with RD_LAT = 2 and i_BUS_DI = 8'h5A -> one RD_n pulse, o_DMA_DI = 8'h5A, and DTACK_n = 0 two cycles after the pulse.
- BR held and BUSAK_n held high with ACK_TO = 15 -> o_ACK_TIMEOUT = 1 after 15 REQ cycles; BUSRQ_n = 1; no re-request until BR toggles 0 then 1.
- i_SNDCPU_RST pulsed during GRANT -> BG_n = 1, BUS_SEL = 0, BUSRQ_n = 1 on the next cycle; a subsequent BR is ignored until dma_en is set again.
